// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA timing generator: field widths, defaults, FSM states,
// the shadowed timing configuration and colour-bar constants (used when VGA_SELF_TEST_EN is defined).
package vga_timing_gen_pkg;

  localparam int HS_W   = 11;
  localparam int HP_W   = 8;
  localparam int HDB_W  = 8;
  localparam int HDE_W  = 10;
  localparam int VS_W   = 9;
  localparam int VP_W   = 3;
  localparam int VDB_W  = 5;
  localparam int VDE_W  = 9;
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 9;

  localparam int COLOR_WIDTH_DEF = 12;
  localparam bit SYNC_POL_DEF    = 1'b0;

  // Colour bars as {R,G,B} on/off flags, expanded to full channel width by vga_color_bar.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [HS_W-1:0]  hsync_end;
    logic [HP_W-1:0]  hpulse_end;
    logic [HDB_W-1:0] hdata_begin;
    logic [HDE_W-1:0] hdata_end;
    logic [VS_W-1:0]  vsync_end;
    logic [VP_W-1:0]  vpulse_end;
    logic [VDB_W-1:0] vdata_begin;
    logic [VDE_W-1:0] vdata_end;
    logic             self_test;
  } timing_cfg_t;

  function automatic logic cfg_valid(input timing_cfg_t c);
    return (c.hsync_end != '0) && (c.vsync_end != '0) &&
           ({2'b0, c.hdata_begin} < c.hdata_end) && ({1'b0, c.hdata_end} <= c.hsync_end) &&
           ({4'b0, c.vdata_begin} < c.vdata_end) && (c.vdata_end <= c.vsync_end);
  endfunction

  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Upstream pixel stream (ping-pong buffer / FIFO) to VGA timing generator, valid/ready handshake.
interface vga_timing_gen_if
  import vga_timing_gen_pkg::*;
#(
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF
);
  logic                   pix_valid_i;
  logic [COLOR_WIDTH-1:0] pix_data_i;
  logic                   pix_ready_o;

  modport master (output pix_valid_i, output pix_data_i, input pix_ready_o);
  modport slave  (input pix_valid_i, input pix_data_i, output pix_ready_o);
endinterface

// File: rtl/vga_color_bar.sv
// Maps a column offset inside the active area to one of eight 64-pixel-wide colour bars.
module vga_color_bar
  import vga_timing_gen_pkg::*;
#(
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF
) (
  input  logic [HCNT_W-1:0]      col_ofs,
  output logic [COLOR_WIDTH-1:0] rgb
);
  localparam int CH_W = COLOR_WIDTH / 3;

  logic [2:0] flags;
  logic       unused_ofs;

  assign flags      = bar_flags(col_ofs[8:6]);
  assign rgb        = {{CH_W{flags[2]}}, {CH_W{flags[1]}}, {CH_W{flags[0]}}};
  assign unused_ofs = ^{col_ofs[HCNT_W-1:9], col_ofs[5:0]};
endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync / active-window generator pulling pixels over valid/ready; timing shadowed per frame.
// Optional colour-bar self test is built only when VGA_SELF_TEST_EN is defined.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF,
  parameter bit SYNC_POL    = SYNC_POL_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable_i,
  input  logic [HS_W-1:0]        hsync_end_i,
  input  logic [HP_W-1:0]        hpulse_end_i,
  input  logic [HDB_W-1:0]       hdata_begin_i,
  input  logic [HDE_W-1:0]       hdata_end_i,
  input  logic [VS_W-1:0]        vsync_end_i,
  input  logic [VP_W-1:0]        vpulse_end_i,
  input  logic [VDB_W-1:0]       vdata_begin_i,
  input  logic [VDE_W-1:0]       vdata_end_i,
  input  logic                   self_test_i,
  vga_timing_gen_if.slave        pix,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   de_o,
  output logic [COLOR_WIDTH-1:0] rgb_o,
  output logic                   frame_start_o,
  output logic                   underflow_o
);
  timing_cfg_t            cfg_in, cfg_q;
  state_t                 state_q, state_d;
  logic [HCNT_W-1:0]      hcnt_p0;
  logic [VCNT_W-1:0]      vcnt_p0;
  logic                   h_last_p0, v_last_p0, eof_p0, run_p0;
  logic                   hs_act_p0, vs_act_p0, active_p0, st_p0, take_p0;
  logic [COLOR_WIDTH-1:0] bar_rgb_p0;

  always_comb begin
    cfg_in.hsync_end   = hsync_end_i;
    cfg_in.hpulse_end  = hpulse_end_i;
    cfg_in.hdata_begin = hdata_begin_i;
    cfg_in.hdata_end   = hdata_end_i;
    cfg_in.vsync_end   = vsync_end_i;
    cfg_in.vpulse_end  = vpulse_end_i;
    cfg_in.vdata_begin = vdata_begin_i;
    cfg_in.vdata_end   = vdata_end_i;
    cfg_in.self_test   = self_test_i;
  end

  assign run_p0    = (state_q == RUN);
  assign h_last_p0 = (hcnt_p0 == cfg_q.hsync_end - 11'd1);
  assign v_last_p0 = (vcnt_p0 == cfg_q.vsync_end - 9'd1);
  assign eof_p0    = run_p0 && h_last_p0 && v_last_p0;

  // A frame only starts or continues on a config that is valid as it gets latched, so a
  // bad APB write can never drive the counters with a nonsensical period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i && cfg_valid(cfg_in)) state_d = RUN;
      RUN:     if (eof_p0 && !(enable_i && cfg_valid(cfg_in))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!run_p0 || eof_p0) cfg_q <= cfg_in;
  end

  always_ff @(posedge clk) begin
    if (!resetn || !run_p0) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= '0;
    end else if (h_last_p0) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= v_last_p0 ? '0 : vcnt_p0 + 9'd1;
    end else begin
      hcnt_p0 <= hcnt_p0 + 11'd1;
    end
  end

  assign hs_act_p0 = (hcnt_p0 < {3'b0, cfg_q.hpulse_end});
  assign vs_act_p0 = (vcnt_p0 < {6'b0, cfg_q.vpulse_end});
  assign active_p0 = run_p0 &&
                     (hcnt_p0 >= {3'b0, cfg_q.hdata_begin}) && (hcnt_p0 < {1'b0, cfg_q.hdata_end}) &&
                     (vcnt_p0 >= {4'b0, cfg_q.vdata_begin}) && (vcnt_p0 < cfg_q.vdata_end);

`ifdef VGA_SELF_TEST_EN
  logic [HCNT_W-1:0] col_ofs_p0;
  assign st_p0      = cfg_q.self_test;
  assign col_ofs_p0 = hcnt_p0 - {3'b0, cfg_q.hdata_begin};
  vga_color_bar #(.COLOR_WIDTH(COLOR_WIDTH)) u_color_bar (
    .col_ofs (col_ofs_p0),
    .rgb     (bar_rgb_p0)
  );
`else
  logic unused_self_test;
  assign st_p0            = 1'b0;
  assign bar_rgb_p0       = '0;
  assign unused_self_test = cfg_q.self_test;
`endif

  assign pix.pix_ready_o = active_p0 && !st_p0;
  assign take_p0         = pix.pix_ready_o && pix.pix_valid_i;

  // p0 -> output registers: everything seen at the pads is one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      de_o          <= 1'b0;
      rgb_o         <= '0;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      hsync_o       <= (run_p0 && hs_act_p0) ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= (run_p0 && vs_act_p0) ? SYNC_POL : ~SYNC_POL;
      de_o          <= active_p0;
      rgb_o         <= (st_p0 && active_p0) ? bar_rgb_p0 : (take_p0 ? pix.pix_data_i : '0);
      frame_start_o <= run_p0 && (hcnt_p0 == '0) && (vcnt_p0 == '0);
      underflow_o   <= pix.pix_ready_o && !pix.pix_valid_i;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized scoreboard bench for vga_timing_gen against a frame-position reference model.
module tb_vga_timing_gen;
  localparam int CW  = 12;
  localparam bit POL = 1'b0;

  typedef struct {
    int hs, hp, hdb, hde, vs, vp, vdb, vde;
    bit st;
  } tcfg_t;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] rgb;
    logic          fs;
    logic          uf;
  } outs_t;

  logic clk = 1'b0;
  logic resetn, enable_i, self_test_i;
  logic [10:0] hsync_end_i;
  logic [7:0]  hpulse_end_i, hdata_begin_i;
  logic [9:0]  hdata_end_i;
  logic [8:0]  vsync_end_i, vdata_end_i;
  logic [2:0]  vpulse_end_i;
  logic [4:0]  vdata_begin_i;
  logic hsync_o, vsync_o, de_o, frame_start_o, underflow_o;
  logic [CW-1:0] rgb_o;

  vga_timing_gen_if #(.COLOR_WIDTH(CW)) pix_if ();

  vga_timing_gen #(.COLOR_WIDTH(CW), .SYNC_POL(POL)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable_i      (enable_i),
    .hsync_end_i   (hsync_end_i),
    .hpulse_end_i  (hpulse_end_i),
    .hdata_begin_i (hdata_begin_i),
    .hdata_end_i   (hdata_end_i),
    .vsync_end_i   (vsync_end_i),
    .vpulse_end_i  (vpulse_end_i),
    .vdata_begin_i (vdata_begin_i),
    .vdata_end_i   (vdata_end_i),
    .self_test_i   (self_test_i),
    .pix           (pix_if),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .de_o          (de_o),
    .rgb_o         (rgb_o),
    .frame_start_o (frame_start_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk = ~clk;

  outs_t out_q[$];
  bit    ready_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Stimulus requests, applied at the next falling edge.
  tcfg_t cfg;
  bit    nxt_resetn, nxt_enable;
  int    seq;

  // Reference model: position inside the frame as a flat cycle index.
  bit    running;
  int    t;
  tcfg_t fc;

  function automatic bit cfg_ok(tcfg_t c);
    return c.hs != 0 && c.vs != 0 && c.hdb < c.hde && c.hde <= c.hs &&
           c.vdb < c.vde && c.vde <= c.vs;
  endfunction

  function automatic outs_t idle_outs();
    outs_t o;
    o.hs = ~POL; o.vs = ~POL; o.de = 1'b0; o.rgb = '0; o.fs = 1'b0; o.uf = 1'b0;
    return o;
  endfunction

`ifdef VGA_SELF_TEST_EN
  function automatic logic [CW-1:0] bar_color(int col);
    logic [CW-1:0] tbl [8];
    tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return tbl[(col / 64) % 8];
  endfunction
`endif

  function automatic tcfg_t small_cfg();
    tcfg_t c;
    c.hs = 20; c.hp = 2; c.hdb = 4; c.hde = 12;
    c.vs = 10; c.vp = 1; c.vdb = 2; c.vde = 8; c.st = 1'b0;
    return c;
  endfunction

  function automatic tcfg_t rand_cfg();
    tcfg_t c;
    c.hs  = $urandom_range(8, 80);
    c.hp  = $urandom_range(0, c.hs);
    c.hdb = $urandom_range(0, c.hs - 2);
    c.hde = $urandom_range(c.hdb + 1, c.hs);
    c.vs  = $urandom_range(3, 15);
    c.vp  = $urandom_range(0, 7);
    c.vdb = $urandom_range(0, c.vs - 2);
    c.vde = $urandom_range(c.vdb + 1, c.vs);
    c.st  = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 9) == 0) c.hde = 0;
    return c;
  endfunction

  task automatic model_step();
    outs_t e;
    bit rdy, act, st;
    int h, v;
    e   = idle_outs();
    rdy = 1'b0;
    if (running) begin
      h   = t % fc.hs;
      v   = t / fc.hs;
      act = (h >= fc.hdb) && (h < fc.hde) && (v >= fc.vdb) && (v < fc.vde);
`ifdef VGA_SELF_TEST_EN
      st = fc.st;
`else
      st = 1'b0;
`endif
      rdy  = act && !st;
      e.hs = (h < fc.hp) ? POL : ~POL;
      e.vs = (v < fc.vp) ? POL : ~POL;
      e.de = act;
      e.fs = (t == 0);
      e.uf = rdy && !pix_if.pix_valid_i;
`ifdef VGA_SELF_TEST_EN
      if (st && act) e.rgb = bar_color(h - fc.hdb);
      else
`endif
      if (rdy && pix_if.pix_valid_i) begin
        e.rgb = pix_if.pix_data_i;
        seq++;
      end
      t++;
      if (t == fc.hs * fc.vs) begin
        t = 0;
        if (enable_i && cfg_ok(cfg)) fc = cfg;
        else running = 1'b0;
      end
    end else if (enable_i && cfg_ok(cfg)) begin
      running = 1'b1;
      t       = 0;
      fc      = cfg;
    end
    if (!resetn) begin
      e       = idle_outs();
      running = 1'b0;
      t       = 0;
    end
    ready_q.push_back(rdy);
    out_q.push_back(e);
  endtask

  task automatic drive_cfg();
    hsync_end_i   = 11'(cfg.hs);
    hpulse_end_i  = 8'(cfg.hp);
    hdata_begin_i = 8'(cfg.hdb);
    hdata_end_i   = 10'(cfg.hde);
    vsync_end_i   = 9'(cfg.vs);
    vpulse_end_i  = 3'(cfg.vp);
    vdata_begin_i = 5'(cfg.vdb);
    vdata_end_i   = 9'(cfg.vde);
    self_test_i   = cfg.st;
  endtask

  task automatic cycle(int vprob, bit incr);
    @(negedge clk);
    resetn             = nxt_resetn;
    enable_i           = nxt_enable;
    drive_cfg();
    pix_if.pix_valid_i = ($urandom_range(0, 99) < vprob);
    pix_if.pix_data_i  = incr ? CW'(seq) : CW'($urandom);
    #1 model_step();
  endtask

  task automatic cycles(int n, int vprob, bit incr);
    for (int i = 0; i < n; i++) cycle(vprob, incr);
  endtask

  outs_t mon_e, mon_a;
  bit    mon_r;

  always @(posedge clk) begin
    #2;
    if (out_q.size() > 0) begin
      mon_e = out_q.pop_front();
      mon_a = {hsync_o, vsync_o, de_o, rgb_o, frame_start_o, underflow_o};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got hs=%b vs=%b de=%b rgb=%h fs=%b uf=%b, expected hs=%b vs=%b de=%b rgb=%h fs=%b uf=%b",
                 $time, mon_a.hs, mon_a.vs, mon_a.de, mon_a.rgb, mon_a.fs, mon_a.uf,
                 mon_e.hs, mon_e.vs, mon_e.de, mon_e.rgb, mon_e.fs, mon_e.uf);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (ready_q.size() > 0) begin
      mon_r = ready_q.pop_front();
      n_cmp++;
      if (pix_if.pix_ready_o !== mon_r) begin
        n_bad++;
        $display("FAIL pix_ready @%0t: got %b expected %b", $time, pix_if.pix_ready_o, mon_r);
      end
    end
  end

  initial begin
    running = 1'b0; t = 0; seq = 0;
    cfg = small_cfg(); fc = cfg;
    nxt_resetn = 1'b0; nxt_enable = 1'b0;
    resetn = 1'b0; enable_i = 1'b0;
    drive_cfg();
    pix_if.pix_valid_i = 1'b0;
    pix_if.pix_data_i  = '0;
    repeat (2) @(posedge clk);

    cycles(3, 100, 1'b1);
    nxt_resetn = 1'b1;
    cycles(4, 100, 1'b1);

    // Two full small frames with an incrementing pixel stream.
    nxt_enable = 1'b1;
    seq = 0;
    cycles(402, 100, 1'b1);

    // Occasional upstream gaps.
    cycles(400, 85, 1'b1);

    // Period change lands on the next frame only.
    cycles(90, 100, 1'b1);
    cfg.hs = 24;
    cycles(560, 100, 1'b1);

    // Drop enable mid-frame, then an invalid config must keep it idle.
    nxt_enable = 1'b0;
    cycles(300, 100, 1'b0);
    cfg = small_cfg();
    cfg.hde = 0;
    nxt_enable = 1'b1;
    cycles(60, 100, 1'b0);

    for (int k = 0; k < 20; k++) begin
      cfg = rand_cfg();
      nxt_enable = ($urandom_range(0, 7) != 0);
      cycles($urandom_range(50, 600), $urandom_range(50, 100), 1'b0);
    end

    // Reset in the middle of a running frame.
    cfg = small_cfg();
    nxt_enable = 1'b1;
    cycles(250, 100, 1'b0);
    nxt_resetn = 1'b0;
    cycles(2, 100, 1'b0);
    nxt_resetn = 1'b1;
    cycles(250, 100, 1'b0);

`ifdef VGA_SELF_TEST_EN
    cfg.hs = 800; cfg.hp = 96; cfg.hdb = 144; cfg.hde = 784;
    cfg.vs = 4; cfg.vp = 1; cfg.vdb = 1; cfg.vde = 3; cfg.st = 1'b1;
    cycles(3400, 100, 1'b0);
`endif

    nxt_enable = 1'b0;
    cycles(5, 100, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
